lif_neuron_array: RTL

//   N_NEURONS parallel leaky integrate-and-fire neurons.

---
 rtl/snn_pkg.sv | 13 +
 rtl/lif_neuron_core.sv | 59 +++++
 rtl/lif_neuron_array.sv | 45 ++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared constants for the spiking-neuron blocks: membrane reset modes and
// the refractory-counter width rule.
package snn_pkg;

    localparam int RESET_ZERO     = 0;
    localparam int RESET_SUBTRACT = 1;

    // A neuron without a refractory period still gets a 1-bit counter that stays at zero.
    function automatic int refr_width(input int refractory);
        return (refractory > 0) ? $clog2(refractory + 1) : 1;
    endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// One leaky integrate-and-fire neuron: saturating leak+input sum, threshold
// compare, selectable post-spike reset and an optional refractory period.
module lif_neuron_core
    import snn_pkg::*;
#(
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 2,
    parameter int REFRACTORY = 0,
    parameter int RESET_MODE = RESET_ZERO
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] syn_in,
    input  logic [W-1:0] threshold,
    output logic         spike
);

    localparam int RW = refr_width(REFRACTORY);

    logic [W-1:0]  state;
    logic [RW-1:0] refr_cnt;
    logic [W-1:0]  leaked;
    logic [W:0]    raw_sum;
    logic [W-1:0]  sum;
    logic          fire;
    logic [W-1:0]  post_spike;

    // The sum is formed one bit wider so an overflow clamps instead of wrapping.
    always_comb begin
        leaked     = state >> LEAK_SHIFT;
        raw_sum    = {1'b0, syn_in} + {1'b0, leaked};
        sum        = raw_sum[W] ? {W{1'b1}} : raw_sum[W-1:0];
        fire       = (sum >= threshold);
        post_spike = (RESET_MODE == RESET_SUBTRACT) ? (sum - threshold) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= '0;
            refr_cnt <= '0;
            spike    <= 1'b0;
        end else if (!in_valid) begin
            spike <= 1'b0;
        end else if (refr_cnt != '0) begin
            refr_cnt <= refr_cnt - 1'b1;
            state    <= '0;
            spike    <= 1'b0;
        end else if (fire) begin
            spike    <= 1'b1;
            refr_cnt <= RW'(REFRACTORY);
            state    <= post_spike;
        end else begin
            spike <= 1'b0;
            state <= sum;
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// N_NEURONS independent LIF neurons sharing one threshold and timestep strobe;
// spikes appear one cycle after the accepted step, qualified by out_valid.
module lif_neuron_array
    import snn_pkg::*;
#(
    parameter int N_NEURONS  = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 2,
    parameter int REFRACTORY = 0,
    parameter int RESET_MODE = RESET_ZERO
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [N_NEURONS*W-1:0] syn_in,
    input  logic [W-1:0]           threshold,
    output logic [N_NEURONS-1:0]   spike,
    output logic                   out_valid
);

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_lane
        lif_neuron_core #(
            .W          (W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRACTORY (REFRACTORY),
            .RESET_MODE (RESET_MODE)
        ) u_core (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .syn_in    (syn_in[i*W +: W]),
            .threshold (threshold),
            .spike     (spike[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule
